// File: rtl/pow32_pkg.sv
// Shared types and constants for the pow32 job scheduler.
// The job struct carries its tag at the default tag width.
package pow32_pkg;

   localparam int OPW      = 32;
   localparam int TAGW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      HOLD
   } state_t;

   typedef struct packed {
      logic [OPW-1:0]      x;
      logic [OPW-1:0]      e;
      logic [TAGW_DEF-1:0] tag;
   } job_t;

endpackage

// File: rtl/pow32_job_fifo.sv
// Synchronous job FIFO with exact occupancy; DEPTH must be a power of two
// so the pointers wrap naturally.
module pow32_job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage has no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/pow32_sched.sv
// Job scheduler in front of pow32: queues jobs, issues them one at a time
// with a load pulse, and returns each result (or a timeout error) in order.
module pow32_sched
   import pow32_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAGW    = TAGW_DEF,
   parameter int TIMEOUT = 4096,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_x,
   input  logic [OPW-1:0]  in_e,
   input  logic [TAGW-1:0] in_tag,
   output logic            eng_ld,
   output logic [OPW-1:0]  eng_x,
   output logic [OPW-1:0]  eng_e,
   input  logic            eng_done,
   input  logic [OPW-1:0]  eng_y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OPW-1:0]  out_y,
   output logic [TAGW-1:0] out_tag,
   output logic            out_err,
   output logic            busy,
   output logic [LW-1:0]   level
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   state_t         state_q, state_d;
   job_t           job_q, job_d, job_in, fifo_dout;
   logic           armed_q, armed_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           valid_d, err_d;
   logic [OPW-1:0] y_d;
   logic [TAGW-1:0] tag_d;
   logic           fifo_full, fifo_empty, push, pop;

   assign in_ready = !fifo_full && rst;
   assign push     = in_valid && in_ready;
   assign eng_x    = job_q.x;
   assign eng_e    = job_q.e;
   assign busy     = (state_q != IDLE) || (level != '0) || out_valid;

   always_comb begin
      job_in     = '0;
      job_in.x   = in_x;
      job_in.e   = in_e;
      job_in.tag = TAGW_DEF'(in_tag);
   end

   pow32_job_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(job_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (job_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // armed guards against a done still high from the previous job.
   always_comb begin
      state_d = state_q;
      job_d   = job_q;
      armed_d = armed_q;
      timer_d = timer_q;
      valid_d = out_valid;
      y_d     = out_y;
      tag_d   = out_tag;
      err_d   = out_err;
      pop     = 1'b0;
      eng_ld  = 1'b0;

      if (out_valid && out_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty && !out_valid) begin
               pop     = 1'b1;
               job_d   = fifo_dout;
               state_d = LOAD;
            end
         end
         LOAD: begin
            eng_ld  = 1'b1;
            armed_d = 1'b0;
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            if (!eng_done) begin
               armed_d = 1'b1;
            end
            if (armed_q && eng_done) begin
               y_d     = eng_y;
               tag_d   = TAGW'(job_q.tag);
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = out_ready ? IDLE : HOLD;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               y_d     = '0;
               tag_d   = TAGW'(job_q.tag);
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         job_q     <= '0;
         armed_q   <= 1'b0;
         timer_q   <= '0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         job_q     <= job_d;
         armed_q   <= armed_d;
         timer_q   <= timer_d;
         out_valid <= valid_d;
         out_y     <= y_d;
         out_tag   <= tag_d;
         out_err   <= err_d;
      end
   end

endmodule
